// File: rtl/song_progress_ctrl.sv
// rtl/song_progress_ctrl.sv - playback state machine and progress-position controller with button debouncing

// Per-button front end: two-flop synchronizer, stability counter, rising-edge press pulse
module song_progress_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // The new level is taken once it has differed from the accepted one for the full window
  assign w_accept = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter, accepted level, and a one-cycle pulse on an accepted rise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && r_sync2;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

// Top: debounced buttons feed a PAUSED/PLAYING/DONE machine that owns the progress bar
module song_progress_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 150_000_000,
  parameter int BAR_MAX         = 140,
  parameter int SEEK_STEP       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_play,
  input  logic       btn_fwd,
  input  logic       btn_back,
  input  logic       restart,
  output logic       song_pause,
  output logic [7:0] progress,
  output logic       song_done
);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [8:0]    BAR9      = 9'(BAR_MAX);
  localparam logic [8:0]    SEEK9     = 9'(SEEK_STEP);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_prog;
  logic [SW-1:0] r_cnt;
  logic          r_pause;
  logic          r_done;

  state_t        w_state_next;
  logic [7:0]    w_prog_next;
  logic [SW-1:0] w_cnt_next;
  logic          w_done_next;
  logic          w_pause_next;

  logic          w_press_play;
  logic          w_press_fwd;
  logic          w_press_back;
  logic          w_seek_fwd;
  logic          w_seek_back;
  logic          w_tick;

  logic [8:0]    w_prog9;
  logic [8:0]    w_sum9;
  logic [8:0]    w_inc9;
  logic          w_fwd_end;
  logic          w_tick_end;
  logic [7:0]    w_fwd_val;
  logic [7:0]    w_back_val;

  song_progress_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_play),
    .o_press (w_press_play)
  );

  song_progress_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fwd (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_fwd),
    .o_press (w_press_fwd)
  );

  song_progress_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_back),
    .o_press (w_press_back)
  );

  // Opposing seeks in the same cycle cancel each other
  assign w_seek_fwd  = w_press_fwd & ~w_press_back;
  assign w_seek_back = w_press_back & ~w_press_fwd;
  assign w_tick      = (r_state == ST_PLAYING) && (r_cnt == STEP_LAST);

  // Position arithmetic is done one bit wider and saturated so progress never wraps
  assign w_prog9    = {1'b0, r_prog};
  assign w_sum9     = w_prog9 + SEEK9;
  assign w_inc9     = w_prog9 + 9'd1;
  assign w_fwd_end  = (w_sum9 >= BAR9);
  assign w_tick_end = (w_inc9 >= BAR9);
  assign w_fwd_val  = w_fwd_end ? BAR9[7:0] : w_sum9[7:0];
  assign w_back_val = (w_prog9 >= SEEK9) ? 8'(w_prog9 - SEEK9) : 8'd0;

  // State, position, step counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_PAUSED;
      r_prog  <= 8'd0;
      r_cnt   <= '0;
      r_pause <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_prog  <= w_prog_next;
      r_cnt   <= w_cnt_next;
      r_pause <= w_pause_next;
      r_done  <= w_done_next;
    end
  end

  // Next state: restart, then seek (which discards any tick), then tick, then play toggle
  always_comb begin
    w_state_next = r_state;
    w_prog_next  = r_prog;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    if (restart) begin
      w_state_next = ST_PAUSED;
      w_prog_next  = 8'd0;
      w_cnt_next   = '0;
    end else begin
      if (w_seek_fwd && (r_state != ST_DONE)) begin
        w_cnt_next  = '0;
        w_prog_next = w_fwd_val;
        if (w_fwd_end) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
        end
      end else if (w_seek_back) begin
        w_cnt_next  = '0;
        w_prog_next = w_back_val;
        if (r_state == ST_DONE) begin
          w_state_next = ST_PAUSED;
        end
      end else if (r_state == ST_PLAYING) begin
        if (w_tick) begin
          w_cnt_next  = '0;
          w_prog_next = w_inc9[7:0];
          if (w_tick_end) begin
            w_state_next = ST_DONE;
            w_done_next  = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      // Toggle acts on the post-seek state; entering DONE this cycle drops it
      if (w_press_play && !w_done_next) begin
        case (w_state_next)
          ST_PAUSED:  w_state_next = ST_PLAYING;
          ST_PLAYING: w_state_next = ST_PAUSED;
          ST_DONE: begin
            w_state_next = ST_PLAYING;
            w_prog_next  = 8'd0;
            w_cnt_next   = '0;
          end
          default:    w_state_next = ST_PAUSED;
        endcase
      end
    end
  end

  // Output decode: the play icon shows whenever the song is not playing
  always_comb begin
    w_pause_next = 1'b1;
    if (w_state_next == ST_PLAYING) begin
      w_pause_next = 1'b0;
    end
  end

  assign song_pause = r_pause;
  assign progress   = r_prog;
  assign song_done  = r_done;
endmodule
